// File: rtl/signed_pow2_div_sequencer_pkg.sv
// Shared types and helpers for signed_pow2_div_sequencer.
// Rounding mode is selected at build time by SIGNED_DIV_ROUND_TOWARD_ZERO_EN.
package signed_pow2_div_pkg;

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  function automatic int min_shift_width(input int n);
    return $clog2(n) + 1;
  endfunction

  // 1: truncate toward zero (C-style), 0: floor (plain arithmetic shift)
`ifdef SIGNED_DIV_ROUND_TOWARD_ZERO_EN
  localparam bit ROUND_TOWARD_ZERO = 1'b1;
`else
  localparam bit ROUND_TOWARD_ZERO = 1'b0;
`endif

endpackage

// File: rtl/signed_pow2_div_sequencer_if.sv
// Upstream request / downstream result handshake bundle for signed_pow2_div_sequencer.
interface signed_pow2_div_sequencer_if #(
  parameter int N  = 8,
  parameter int SW = 4
);
  import signed_pow2_div_pkg::*;

  logic          up_valid;
  logic          up_ready;
  logic [N-1:0]  up_data;
  logic [SW-1:0] up_shift;
  logic          down_valid;
  logic          down_ready;
  logic [N-1:0]  down_data;
  logic          busy;

  modport master (
    output up_valid, up_data, up_shift, down_ready,
    input  up_ready, down_valid, down_data, busy
  );

  modport slave (
    input  up_valid, up_data, up_shift, down_ready,
    output up_ready, down_valid, down_data, busy
  );

endinterface

// File: rtl/signed_pow2_div_sequencer_shr1.sv
// Single-bit arithmetic right shift stage, reused once per SHIFT cycle.
module arith_shift_right_by_one_sticky
  import signed_pow2_div_pkg::*;
#(
  parameter int N = 8
) (
  input  logic [N-1:0] work,
  output logic [N-1:0] shifted,
  output logic         lsb
);

  assign shifted = {work[N-1], work[N-1:1]};
  assign lsb     = work[0];

endmodule

// File: rtl/signed_pow2_div_sequencer.sv
// Sequential signed divide by 2^k using one reused 1-bit arithmetic shifter.
// Define SIGNED_DIV_ROUND_TOWARD_ZERO_EN for truncating (C-style) results instead of floor.
module signed_pow2_div_sequencer
  import signed_pow2_div_pkg::*;
#(
  parameter int N  = 8,
  parameter int SW = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  signed_pow2_div_sequencer_if.slave bus
);

  state_t        state, state_next;
  logic [N-1:0]  work, work_next, shifted;
  logic [SW-1:0] cnt, cnt_next, keff;
  logic          lsb;

  arith_shift_right_by_one_sticky #(.N(N)) u_shr1 (
    .work    (work),
    .shifted (shifted),
    .lsb     (lsb)
  );

  // Shift amounts of N or more all give the same result, so clamp once at accept
  assign keff = (bus.up_shift > SW'(N)) ? SW'(N) : bus.up_shift;

`ifdef SIGNED_DIV_ROUND_TOWARD_ZERO_EN
  logic sticky, sticky_next, sign;
`else
  logic unused_lsb;
  assign unused_lsb = lsb;
`endif

  always_comb begin
    state_next = state;
    work_next  = work;
    cnt_next   = cnt;
`ifdef SIGNED_DIV_ROUND_TOWARD_ZERO_EN
    sticky_next = sticky;
`endif
    unique case (state)
      IDLE: begin
        if (bus.up_valid) begin
          work_next  = bus.up_data;
          cnt_next   = keff;
          state_next = (keff == '0) ? DONE : SHIFT;
`ifdef SIGNED_DIV_ROUND_TOWARD_ZERO_EN
          sticky_next = 1'b0;
`endif
        end
      end
      SHIFT: begin
        work_next = shifted;
        cnt_next  = cnt - SW'(1);
`ifdef SIGNED_DIV_ROUND_TOWARD_ZERO_EN
        sticky_next = sticky | lsb;
`endif
        if (cnt == SW'(1)) begin
          state_next = DONE;
`ifdef SIGNED_DIV_ROUND_TOWARD_ZERO_EN
          // Negative inexact results are pulled up one step toward zero
          if (sign && sticky_next)
            work_next = shifted + N'(1);
`endif
        end
      end
      DONE: begin
        if (bus.down_ready)
          state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      work  <= '0;
      cnt   <= '0;
    end else begin
      state <= state_next;
      work  <= work_next;
      cnt   <= cnt_next;
    end
  end

`ifdef SIGNED_DIV_ROUND_TOWARD_ZERO_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      sticky <= 1'b0;
      sign   <= 1'b0;
    end else begin
      sticky <= sticky_next;
      if (state == IDLE && bus.up_valid)
        sign <= bus.up_data[N-1];
    end
  end
`endif

  assign bus.up_ready   = (state == IDLE) && !rst;
  assign bus.down_valid = (state == DONE);
  assign bus.busy       = (state != IDLE);
  assign bus.down_data  = work;

endmodule
